// File: rtl/ctrl_pipe_pkg.sv
// Shared condition codes, flag indices and condition evaluation for ctrl_pipe.
// Purely combinational helpers; no state, no flow control.
package ctrl_pipe_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, res;
    n   = nzcv[FLAG_N];
    z   = nzcv[FLAG_Z];
    c   = nzcv[FLAG_C];
    v   = nzcv[FLAG_V];
    res = 1'b0;
    case (cond)
      COND_EQ: res = z;
      COND_NE: res = ~z;
      COND_CS: res = c;
      COND_CC: res = ~c;
      COND_MI: res = n;
      COND_PL: res = ~n;
      COND_VS: res = v;
      COND_VC: res = ~v;
      COND_HI: res = c & ~z;
      COND_LS: res = ~c | z;
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = ~z & (n == v);
      COND_LE: res = z | (n != v);
      COND_AL: res = 1'b1;
      COND_NV: res = 1'b0;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ctrl_pipe_cond.sv
// NZCV flag register plus condition evaluation for the instruction in Execute.
// cond_ex is combinational from flags_q; flags update 1 cycle later, suppressed by stall.
module cond_unit_p
  import ctrl_pipe_pkg::*;
#(
  parameter int COND_EN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_write,
  input  logic       stall,
  output logic       cond_ex,
  output logic [3:0] flags
);

  logic [3:0] flags_d, flags_q;
  logic       we_nz, we_cv;

  always_comb begin
    cond_ex = (COND_EN != 0) ? cond_eval(cond, flags_q) : 1'b1;
    we_nz   = flag_write[FW_NZ] & cond_ex & ~stall;
    we_cv   = flag_write[FW_CV] & cond_ex & ~stall;
    flags_d = flags_q;
    if (we_nz) begin
      flags_d[FLAG_N] = alu_flags[FLAG_N];
      flags_d[FLAG_Z] = alu_flags[FLAG_Z];
    end
    if (we_cv) begin
      flags_d[FLAG_C] = alu_flags[FLAG_C];
      flags_d[FLAG_V] = alu_flags[FLAG_V];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= 4'b0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;

endmodule

// File: rtl/ctrl_pipe_flopenrc.sv
// Generic W-bit register with enable and synchronous clear, async active-low reset.
// Latency 1; holds when en is low, clr loads zero only when enabled.
module flopenrc #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = clr ? '0 : d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Control-path pipeline D->E->M->W with conditional execution gating, 1 cycle per stage.
// StallE holds E and bubbles M; FlushE bubbles E and wins over StallE.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int ALUCTRL_W = 2,
  parameter int COND_EN   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 PCSrcD,
  input  logic                 RegWriteD,
  input  logic                 MemtoRegD,
  input  logic                 MemWriteD,
  input  logic                 BranchD,
  input  logic                 ALUSrcD,
  input  logic                 NoWriteD,
  input  logic [ALUCTRL_W-1:0] ALUControlD,
  input  logic [1:0]           FlagWriteD,
  input  logic [3:0]           CondD,
  input  logic [3:0]           ALUFlags,
  input  logic                 FlushE,
  input  logic                 StallE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 ALUSrcE,
  output logic                 MemtoRegE,
  output logic                 BranchTakenE,
  output logic                 PCSrcE,
  output logic                 CondExE,
  output logic                 PCSrcM,
  output logic                 RegWriteM,
  output logic                 MemWriteM,
  output logic                 PCSrcW,
  output logic                 RegWriteW,
  output logic                 MemtoRegW,
  output logic [3:0]           FlagsQ
);

  localparam int DE_W = 9 + ALUCTRL_W + 4;

  logic [DE_W-1:0]      de_d, de_q;
  logic [3:0]           em_d, em_q;
  logic [2:0]           mw_d, mw_q;

  logic                 pcsrc_e, regwrite_e, memtoreg_e, memwrite_e;
  logic                 branch_e, alusrc_e, nowrite_e;
  logic [ALUCTRL_W-1:0] aluctrl_e;
  logic [1:0]           flagwrite_e;
  logic [3:0]           cond_e;
  logic                 cond_ex;
  logic                 regwrite_ec, memwrite_ec, pcsrc_ec;
  logic                 de_en;

  always_comb begin
    de_d  = {PCSrcD, RegWriteD, MemtoRegD, MemWriteD, ALUControlD,
             BranchD, ALUSrcD, FlagWriteD, NoWriteD, CondD};
    de_en = ~StallE | FlushE;
  end

  flopenrc #(.W(DE_W)) u_de (
    .clk   (clk),
    .reset (reset),
    .en    (de_en),
    .clr   (FlushE),
    .d     (de_d),
    .q     (de_q)
  );

  assign {pcsrc_e, regwrite_e, memtoreg_e, memwrite_e, aluctrl_e,
          branch_e, alusrc_e, flagwrite_e, nowrite_e, cond_e} = de_q;

  cond_unit_p #(.COND_EN(COND_EN)) u_cond (
    .clk        (clk),
    .reset      (reset),
    .cond       (cond_e),
    .alu_flags  (ALUFlags),
    .flag_write (flagwrite_e),
    .stall      (StallE),
    .cond_ex    (cond_ex),
    .flags      (FlagsQ)
  );

  // A stalled instruction stays in E, so M must see a bubble rather than a duplicate.
  always_comb begin
    regwrite_ec = regwrite_e & cond_ex & ~nowrite_e;
    memwrite_ec = memwrite_e & cond_ex;
    pcsrc_ec    = pcsrc_e & cond_ex;
    em_d        = {pcsrc_ec, regwrite_ec, memtoreg_e, memwrite_ec};
    mw_d        = em_q[3:1];
  end

  flopenrc #(.W(4)) u_em (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (StallE),
    .d     (em_d),
    .q     (em_q)
  );

  flopenrc #(.W(3)) u_mw (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (1'b0),
    .d     (mw_d),
    .q     (mw_q)
  );

  assign ALUControlE  = aluctrl_e;
  assign ALUSrcE      = alusrc_e;
  assign MemtoRegE    = memtoreg_e;
  assign PCSrcE       = pcsrc_e;
  assign CondExE      = cond_ex;
  assign BranchTakenE = branch_e & cond_ex & ~StallE;
  assign PCSrcM       = em_q[3];
  assign RegWriteM    = em_q[2];
  assign MemWriteM    = em_q[0];
  assign PCSrcW       = mw_q[2];
  assign RegWriteW    = mw_q[1];
  assign MemtoRegW    = mw_q[0];

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboarded random + directed bench for two ctrl_pipe configurations.
module tb_ctrl_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       pcsrc_d, regwrite_d, memtoreg_d, memwrite_d, branch_d, alusrc_d, nowrite_d;
  logic [3:0] alu_d;
  logic [1:0] fw_d;
  logic [3:0] cond_d, alu_flags;
  logic       flush_e, stall_e;

  typedef struct packed {
    logic [7:0] alu;
    logic       alusrc, memtoreg_e, btaken, pcsrc_e, condex;
    logic       pcsrc_m, regwrite_m, memwrite_m;
    logic       pcsrc_w, regwrite_w, memtoreg_w;
    logic [3:0] flags;
  } obs_t;

  typedef struct packed {
    logic       pcsrc, regwrite, memtoreg, memwrite, branch, alusrc;
    logic [1:0] fw;
    logic       nowrite;
    logic [7:0] alu;
    logic [3:0] cond;
  } instr_t;

  // Instance 0: defaults (ALUCTRL_W=2, COND_EN=1). Instance 1: ALUCTRL_W=4, COND_EN=0.
  logic [1:0] a0_alu;
  logic       a0_alusrc, a0_mte, a0_bt, a0_pce, a0_cx, a0_pcm, a0_rwm, a0_mwm, a0_pcw, a0_rww, a0_mtw;
  logic [3:0] a0_flags;
  logic [3:0] a1_alu;
  logic       a1_alusrc, a1_mte, a1_bt, a1_pce, a1_cx, a1_pcm, a1_rwm, a1_mwm, a1_pcw, a1_rww, a1_mtw;
  logic [3:0] a1_flags;

  ctrl_pipe dut0 (
    .clk(clk), .reset(reset), .PCSrcD(pcsrc_d), .RegWriteD(regwrite_d), .MemtoRegD(memtoreg_d),
    .MemWriteD(memwrite_d), .BranchD(branch_d), .ALUSrcD(alusrc_d), .NoWriteD(nowrite_d),
    .ALUControlD(alu_d[1:0]), .FlagWriteD(fw_d), .CondD(cond_d), .ALUFlags(alu_flags),
    .FlushE(flush_e), .StallE(stall_e), .ALUControlE(a0_alu), .ALUSrcE(a0_alusrc),
    .MemtoRegE(a0_mte), .BranchTakenE(a0_bt), .PCSrcE(a0_pce), .CondExE(a0_cx),
    .PCSrcM(a0_pcm), .RegWriteM(a0_rwm), .MemWriteM(a0_mwm), .PCSrcW(a0_pcw),
    .RegWriteW(a0_rww), .MemtoRegW(a0_mtw), .FlagsQ(a0_flags)
  );

  ctrl_pipe #(.ALUCTRL_W(4), .COND_EN(0)) dut1 (
    .clk(clk), .reset(reset), .PCSrcD(pcsrc_d), .RegWriteD(regwrite_d), .MemtoRegD(memtoreg_d),
    .MemWriteD(memwrite_d), .BranchD(branch_d), .ALUSrcD(alusrc_d), .NoWriteD(nowrite_d),
    .ALUControlD(alu_d), .FlagWriteD(fw_d), .CondD(cond_d), .ALUFlags(alu_flags),
    .FlushE(flush_e), .StallE(stall_e), .ALUControlE(a1_alu), .ALUSrcE(a1_alusrc),
    .MemtoRegE(a1_mte), .BranchTakenE(a1_bt), .PCSrcE(a1_pce), .CondExE(a1_cx),
    .PCSrcM(a1_pcm), .RegWriteM(a1_rwm), .MemWriteM(a1_mwm), .PCSrcW(a1_pcw),
    .RegWriteW(a1_rww), .MemtoRegW(a1_mtw), .FlagsQ(a1_flags)
  );

  obs_t obs0, obs1;
  assign obs0 = '{alu: {6'b0, a0_alu}, alusrc: a0_alusrc, memtoreg_e: a0_mte, btaken: a0_bt,
                  pcsrc_e: a0_pce, condex: a0_cx, pcsrc_m: a0_pcm, regwrite_m: a0_rwm,
                  memwrite_m: a0_mwm, pcsrc_w: a0_pcw, regwrite_w: a0_rww, memtoreg_w: a0_mtw,
                  flags: a0_flags};
  assign obs1 = '{alu: {4'b0, a1_alu}, alusrc: a1_alusrc, memtoreg_e: a1_mte, btaken: a1_bt,
                  pcsrc_e: a1_pce, condex: a1_cx, pcsrc_m: a1_pcm, regwrite_m: a1_rwm,
                  memwrite_m: a1_mwm, pcsrc_w: a1_pcw, regwrite_w: a1_rww, memtoreg_w: a1_mtw,
                  flags: a1_flags};

  // Reference model: per instance, the instruction in E, the flags, and what M and W hold.
  instr_t     m_e   [2];
  logic [3:0] m_fl  [2];
  logic [3:0] m_m   [2];   // {pcsrc, regwrite, memtoreg, memwrite}
  logic [2:0] m_w   [2];   // {pcsrc, regwrite, memtoreg}

  obs_t q0[$], q1[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  // ARM rule: cond[3:1] selects a base test, cond[0] inverts it; 0xE always, 0xF never.
  function automatic logic ref_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, b;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    if (cond == 4'hE) return 1'b1;
    if (cond == 4'hF) return 1'b0;
    case (cond[3:1])
      3'd0:    b = z;
      3'd1:    b = c;
      3'd2:    b = n;
      3'd3:    b = v;
      3'd4:    b = c && !z;
      3'd5:    b = (n == v);
      default: b = !z && (n == v);
    endcase
    return cond[0] ? !b : b;
  endfunction

  function automatic logic m_cx(input int i);
    return (i == 1) ? 1'b1 : ref_cond(m_e[i].cond, m_fl[i]);
  endfunction

  function automatic obs_t m_expect(input int i);
    obs_t o;
    logic c;
    c            = m_cx(i);
    o.alu        = m_e[i].alu;
    o.alusrc     = m_e[i].alusrc;
    o.memtoreg_e = m_e[i].memtoreg;
    o.btaken     = m_e[i].branch && c && !stall_e;
    o.pcsrc_e    = m_e[i].pcsrc;
    o.condex     = c;
    o.pcsrc_m    = m_m[i][3];
    o.regwrite_m = m_m[i][2];
    o.memwrite_m = m_m[i][0];
    o.pcsrc_w    = m_w[i][2];
    o.regwrite_w = m_w[i][1];
    o.memtoreg_w = m_w[i][0];
    o.flags      = m_fl[i];
    return o;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 2; i++) begin
      m_e[i] = '0; m_fl[i] = 4'b0; m_m[i] = 4'b0; m_w[i] = 3'b0;
    end
  endtask

  task automatic m_step();
    instr_t din;
    logic   c;
    for (int i = 0; i < 2; i++) begin
      din = '{pcsrc: pcsrc_d, regwrite: regwrite_d, memtoreg: memtoreg_d, memwrite: memwrite_d,
              branch: branch_d, alusrc: alusrc_d, fw: fw_d, nowrite: nowrite_d,
              alu: (i == 0) ? {6'b0, alu_d[1:0]} : {4'b0, alu_d}, cond: cond_d};
      c = m_cx(i);
      m_w[i] = m_m[i][3:1];
      if (stall_e) m_m[i] = 4'b0;
      else m_m[i] = {m_e[i].pcsrc && c, m_e[i].regwrite && c && !m_e[i].nowrite,
                     m_e[i].memtoreg, m_e[i].memwrite && c};
      if (!stall_e && c) begin
        if (m_e[i].fw[1]) m_fl[i][3:2] = alu_flags[3:2];
        if (m_e[i].fw[0]) m_fl[i][1:0] = alu_flags[1:0];
      end
      if (flush_e) m_e[i] = '0;
      else if (!stall_e) m_e[i] = din;
    end
  endtask

  // Called just after a rising edge with this cycle's inputs applied.
  task automatic tick();
    if (!reset) m_clear();
    q0.push_back(m_expect(0));
    q1.push_back(m_expect(1));
    @(posedge clk);
    if (reset) m_step();
    else m_clear();
    cyc++;
    #1;
  endtask

  task automatic clear_d();
    pcsrc_d = 0; regwrite_d = 0; memtoreg_d = 0; memwrite_d = 0; branch_d = 0;
    alusrc_d = 0; nowrite_d = 0; alu_d = 4'h0; fw_d = 2'b00; cond_d = 4'h0;
    flush_e = 0; stall_e = 0;
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        compared++;
        if (obs0 !== e) begin
          mismatched++;
          $display("FAIL cfg0_outputs cyc=%0d got=%h expected=%h", cyc, obs0, e);
        end
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        compared++;
        if (obs1 !== e) begin
          mismatched++;
          $display("FAIL cfg1_outputs cyc=%0d got=%h expected=%h", cyc, obs1, e);
        end
      end
    end
  end

  initial begin : stimulus
    reset = 1'b0;
    clear_d();
    alu_flags = 4'h0;
    m_clear();
    @(posedge clk);
    #1;
    tick(); tick();
    reset = 1'b1;
    tick();

    // Reset dropped mid-stream while RegWrite instructions are in flight.
    regwrite_d = 1; cond_d = 4'hE; tick();
    tick();
    reset = 1'b0; tick();
    reset = 1'b1; clear_d(); repeat (4) tick();

    // Flag-setting compare, then EQ and NE consumers.
    fw_d = 2'b11; cond_d = 4'hE; tick();
    clear_d(); alu_flags = 4'b0100; regwrite_d = 1; cond_d = 4'h0; tick();
    clear_d(); alu_flags = 4'b0000; regwrite_d = 1; cond_d = 4'h1; tick();
    clear_d(); repeat (3) tick();

    // Partial flag write: NZCV=1111, then write only C,V with 00.
    fw_d = 2'b11; cond_d = 4'hE; tick();
    clear_d(); alu_flags = 4'b1111; fw_d = 2'b01; cond_d = 4'hE; tick();
    clear_d(); alu_flags = 4'b0000; tick();
    clear_d(); repeat (2) tick();

    // Branch held by a 2-cycle stall.
    branch_d = 1; pcsrc_d = 1; cond_d = 4'hE; fw_d = 2'b11; tick();
    clear_d(); alu_flags = 4'b1010; stall_e = 1; tick(); tick();
    stall_e = 0; repeat (3) tick();

    // Flush and stall together on a store.
    memwrite_d = 1; alu_d = 4'h3; cond_d = 4'hE; tick();
    clear_d(); flush_e = 1; stall_e = 1; tick();
    clear_d(); repeat (2) tick();

    // Never-condition with RegWrite and a wide ALU opcode.
    regwrite_d = 1; cond_d = 4'hF; alu_d = 4'hA; tick();
    clear_d(); repeat (4) tick();

    for (int k = 0; k < 400; k++) begin
      pcsrc_d    = 1'($urandom_range(0, 1));
      regwrite_d = 1'($urandom_range(0, 1));
      memtoreg_d = 1'($urandom_range(0, 1));
      memwrite_d = 1'($urandom_range(0, 1));
      branch_d   = 1'($urandom_range(0, 1));
      alusrc_d   = 1'($urandom_range(0, 1));
      nowrite_d  = ($urandom_range(0, 3) == 0);
      alu_d      = 4'($urandom_range(0, 15));
      fw_d       = 2'($urandom_range(0, 3));
      cond_d     = 4'($urandom_range(0, 15));
      alu_flags  = 4'($urandom_range(0, 15));
      stall_e    = ($urandom_range(0, 6) == 0);
      flush_e    = ($urandom_range(0, 9) == 0);
      reset      = ($urandom_range(0, 79) != 0);
      tick();
    end

    reset = 1'b1;
    clear_d();
    repeat (3) tick();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Parametrised control-path pipeline for the pipelined processor: takes the decoded control bundle in Decode and carries it through the Execute, Memory and Writeback register stages. It evaluates the full 16-code condition field against an NZCV flag register and gates the state-changing controls by the result. It adds an Execute stall, a configurable ALU-control width and a compile-time conditional-execution mode. It sits between the decoder and the datapath/hazard unit.

## Interface
- ALUCTRL_W, 2: ALU control width (1..8).
- COND_EN, 1: 1 = evaluate the condition field; 0 = CondExE is constant 1 and the flag register still updates.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; clears every register.
- PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, NoWriteD  in  1 each  decoded controls.
- ALUControlD  in  ALUCTRL_W  ALU operation.
- FlagWriteD  in  2  bit1 writes N,Z; bit0 writes C,V.
- CondD  in  4  condition field, Instr[31:28].
- ALUFlags  in  4  {N,Z,C,V} from the ALU in Execute.
- FlushE  in  1  load a bubble into E at the next edge.
- StallE  in  1  hold E and insert a bubble into M.
- ALUControlE  out  ALUCTRL_W.
- ALUSrcE, MemtoRegE, BranchTakenE, PCSrcE, CondExE  out  1 each.
- PCSrcM, RegWriteM, MemWriteM  out  1 each.
- PCSrcW, RegWriteW, MemtoRegW  out  1 each.
- FlagsQ  out  4  architectural NZCV register.

## Operation
- D→E register width: 9+ALUCTRL_W+4. Fields: PCSrc, RegWrite, MemtoReg, MemWrite, ALUControl, Branch, ALUSrc, FlagWrite[1:0], NoWrite, Cond.
- Condition codes follow ARM encoding 0x0 EQ … 0xD LE, 0xE AL. 0xF is treated as never (CondExE=0).
- Gated signals in Execute:
  - RegWriteEc = RegWriteE & CondExE & ~NoWriteE
  - MemWriteEc = MemWriteE & CondExE
  - PCSrcEc = PCSrcE & CondExE
  - BranchTakenE = BranchE & CondExE & ~StallE
- Flag register update:
  - N,Z ← ALUFlags[3:2] when FlagWriteE[1] & CondExE & ~StallE.
  - C,V ← ALUFlags[1:0] when FlagWriteE[0] & CondExE & ~StallE.
- E→M register: {PCSrcEc, RegWriteEc, MemtoRegE, MemWriteEc}. M→W register: {PCSrcM, RegWriteM, MemtoRegM}.
- A bubble is all control fields zero, which gives CondExE = EQ on the current flags but no side effects.
- StallE=1:
  - The E register holds.
  - The E→M register loads a bubble.
  - The flags are not written.
  - M→W advances normally.
- FlushE=1: the E register loads a bubble. FlushE has priority over StallE; when both are asserted, E clears and M still receives a bubble.
- Reset (asserted low at any time, including mid-stream): all pipeline registers and FlagsQ are 0 immediately. Outputs go to 0, except CondExE, which evaluates EQ on Z=0 and therefore reads 0.

## Timing
- Decode→Execute latency 1 cycle; Execute→Memory 1; Memory→Writeback 1. RegWriteW trails RegWriteD by 3 cycles absent stalls.
- CondExE, BranchTakenE and the gated Execute signals are combinational from the E register and FlagsQ in the same cycle.
- A flag update is visible to the next instruction in Execute: FlagsQ is written at the edge, and the following E-stage condition sees the new value.
- There is no flag bypass within the same instruction.
- StallE of k cycles inserts exactly k bubbles in M and W. Each instruction writes flags and asserts BranchTakenE exactly once.

## Structure
- Shared package entries:
  - Condition-code constants COND_EQ…COND_NV.
  - FlagWrite bit indices.
  - Function cond_eval(cond, nzcv).
- One sub-module: cond_unit_p holds the 4-bit flag register, cond_eval and the per-half write enables, parametrised by COND_EN.
- Pipeline registers use the existing flopr/floprc style with an added enable; one generic flopenrc #(W) is instantiated three times.

## Test plan
- Reset mid-stream: issue RegWriteD=1 and drop reset on cycle 2 → all outputs 0 immediately and FlagsQ=0; after release the pipeline restarts empty.
- Flag-setting compare:
  - Instruction with FlagWriteD=2'b11, CondD=AL and ALUFlags=4'b0100 → FlagsQ=0100 one edge later.
  - Next instruction with CondD=EQ → CondExE=1; with CondD=NE → RegWriteM=0.
- Partial flag write: FlagsQ=1111, then FlagWriteD=2'b01 with ALUFlags=0000 → FlagsQ=1100.
- Stall: branch with CondD=AL and StallE held 2 cycles → BranchTakenE=0 for 2 cycles, then 1 for exactly one cycle; PCSrcM shows 2 bubbles then 1.
- Flush vs stall: FlushE=1 and StallE=1 together with a MemWrite instruction in E → MemWriteM=0 next cycle and ALUControlE=0.
- COND_EN=0 with CondD=4'hF and RegWriteD=1 → RegWriteW=1 after 3 cycles; ALUCTRL_W=4 with ALUControlD=4'hA → ALUControlE=4'hA.
